// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART transmit path
package uart_pkg;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int PRESCALE_MIN = 4;
    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD = 1'b1;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: parallel load side and serial line of the UART transmitter
interface uart_tx_if import uart_pkg::*; #(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int PRESCALE_W = 6
);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Data_Valid;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic [PRESCALE_W-1:0] Prescale;
    logic                  TX_OUT;
    logic                  Busy;
    modport master (output P_DATA, Data_Valid, PAR_EN, PAR_TYP, Prescale, input TX_OUT, Busy);
    modport slave (input P_DATA, Data_Valid, PAR_EN, PAR_TYP, Prescale, output TX_OUT, Busy);
endinterface

// File: rtl/uart_tx_bit_timer.sv
// uart_tx_bit_timer: counts clocks within a bit and data bits within a frame
module uart_tx_bit_timer #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6,
    parameter int BW = 3
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  en,
    input  logic                  data_phase,
    input  logic [PRESCALE_W-1:0] n,
    output logic                  bit_done,
    output logic                  last_data_bit,
    output logic [BW-1:0]         bit_cnt
);
    logic [PRESCALE_W-1:0] edge_cnt;

    assign bit_done = en && edge_cnt == n - 1'b1;
    assign last_data_bit = bit_cnt == BW'(DATA_WIDTH - 1);

    // edge_cnt wraps at the end of every bit; bit_cnt only runs during data bits
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            edge_cnt <= '0;
            bit_cnt <= '0;
        end else begin
            edge_cnt <= (!en || bit_done) ? '0 : edge_cnt + 1'b1;
            bit_cnt <= !data_phase ? '0 : bit_done ? bit_cnt + 1'b1 : bit_cnt;
        end
    end
endmodule

// File: rtl/uart_tx.sv
// uart_tx: serialises a byte as start, data LSB first, optional parity, stop
module uart_tx import uart_pkg::*; #(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int PRESCALE_W = 6
) (
    input  logic      CLK,
    input  logic      RST,
    uart_tx_if.slave  bus
);
    localparam int BW = $clog2(DATA_WIDTH);
    localparam logic [PRESCALE_W-1:0] N_MIN = PRESCALE_W'(PRESCALE_MIN);

    tx_state_t             state, state_d;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  par_en_q, par_q;
    logic [PRESCALE_W-1:0] n_q;
    logic                  accept, bit_done, last_data_bit;
    logic                  tx_d, busy_d, tx_q, busy_q;
    logic [BW-1:0]         bit_cnt, bit_nxt;

    assign accept = bus.Data_Valid && state == IDLE;
    assign bus.TX_OUT = tx_q;
    assign bus.Busy = busy_q;

    uart_tx_bit_timer #(.DATA_WIDTH(DATA_WIDTH), .PRESCALE_W(PRESCALE_W), .BW(BW)) u_timer (
        .CLK(CLK),
        .RST(RST),
        .en(state != IDLE),
        .data_phase(state == DATA),
        .n(n_q),
        .bit_done(bit_done),
        .last_data_bit(last_data_bit),
        .bit_cnt(bit_cnt)
    );

    // snapshot the frame configuration so later input changes cannot disturb it
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            data_q <= '0;
            par_en_q <= 1'b0;
            par_q <= 1'b0;
            n_q <= '0;
        end else if (accept) begin
            data_q <= bus.P_DATA;
            par_en_q <= bus.PAR_EN;
            par_q <= ^bus.P_DATA ^ (bus.PAR_TYP == PAR_ODD);
            n_q <= bus.Prescale < N_MIN ? N_MIN : bus.Prescale;
        end
    end

    // state register with the line and busy flag registered alongside it
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
            tx_q <= 1'b1;
            busy_q <= 1'b0;
        end else begin
            state <= state_d;
            tx_q <= tx_d;
            busy_q <= busy_d;
        end
    end

    // frame sequencing, advancing on the last clock of each bit
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    state_d = accept ? START : IDLE;
            START:   state_d = bit_done ? DATA : START;
            DATA:    state_d = (bit_done && last_data_bit) ? (par_en_q ? PARITY : STOP) : DATA;
            PARITY:  state_d = bit_done ? STOP : PARITY;
            STOP:    state_d = bit_done ? IDLE : STOP;
            default: state_d = IDLE;
        endcase
    end

    // line value for the coming cycle, derived from the next state and bit index
    always_comb begin
        bit_nxt = state != DATA ? '0 : bit_done ? bit_cnt + 1'b1 : bit_cnt;
        tx_d = state_d == START ? 1'b0 :
               state_d == DATA ? data_q[bit_nxt] :
               state_d == PARITY ? par_q : 1'b1;
        busy_d = state_d != IDLE;
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench decoding frames on the serial line
module tb_uart_tx;
    import uart_pkg::*;

    typedef struct {
        logic [10:0] bits;
        int          nb;
        int          n;
        int          gap;
        bit          abort;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    exp_t q[$];

    uart_tx_if bus ();

    uart_tx dut (.CLK(clk), .RST(rst), .bus(bus.slave));

    always #5 clk = ~clk;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic start(logic [7:0] d, bit pe, bit pt, logic [5:0] ps, exp_t e);
        q.push_back(e);
        bus.P_DATA = d;
        bus.PAR_EN = pe;
        bus.PAR_TYP = pt;
        bus.Prescale = ps;
        bus.Data_Valid = 1'b1;
        @(posedge clk);
        #1;
        bus.Data_Valid = 1'b0;
        bus.P_DATA = ~d;
        bus.PAR_EN = !pe;
        bus.PAR_TYP = !pt;
        bus.Prescale = 6'd5;
        chk("start_latency", {bus.Busy, bus.TX_OUT}, 2'b10);
    endtask

    task automatic wait_idle();
        int i = 0;
        while (bus.Busy && i < 3000) begin
            @(posedge clk);
            #1;
            i++;
        end
        chk("idle_timeout", bus.Busy, 0);
    endtask

    // monitor: pops the expected frame when Busy rises and checks each bit, length and gap
    initial begin
        bit   prev = 0;
        bit   bad = 0;
        int   cnt = 0;
        int   idle = 0;
        int   b;
        exp_t cur = '{bits: 11'h7ff, nb: 0, n: 4, gap: -1, abort: 1};
        forever begin
            @(negedge clk);
            if (bus.Busy && !prev) begin
                if (q.size() == 0) begin
                    errors++;
                    checks++;
                    $display("FAIL unexpected_frame: got a frame expected none at %0t", $time);
                    cur = '{bits: 11'h7ff, nb: 0, n: 4, gap: -1, abort: 1};
                end else begin
                    cur = q.pop_front();
                    if (cur.gap >= 0) chk("idle_gap", idle, cur.gap);
                end
                cnt = 0;
                bad = 0;
            end
            if (bus.Busy) begin
                b = cnt / cur.n;
                if (b < cur.nb && bus.TX_OUT !== cur.bits[b]) bad = 1;
                if (b < cur.nb && cnt % cur.n == cur.n - 1) begin
                    chk($sformatf("frame_bit%0d", b), bad, 0);
                    bad = 0;
                end
                cnt++;
            end else begin
                if (prev && !cur.abort) chk("busy_length", cnt, cur.nb * cur.n);
                idle = prev ? 1 : idle + 1;
            end
            prev = bus.Busy;
        end
    end

    initial begin
        bus.P_DATA = '0;
        bus.Data_Valid = 1'b0;
        bus.PAR_EN = 1'b0;
        bus.PAR_TYP = 1'b0;
        bus.Prescale = 6'd8;
        #2 rst = 1'b0;
        #1;
        chk("reset_tx", bus.TX_OUT, 1);
        chk("reset_busy", bus.Busy, 0);
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;
        start(8'hA5, 1, PAR_EVEN, 6'd8, '{bits: 11'b10101001010, nb: 11, n: 8, gap: -1, abort: 0});
        wait_idle();
        chk("idle_after_a5", bus.TX_OUT, 1);
        start(8'hA5, 1, PAR_ODD, 6'd8, '{bits: 11'b11101001010, nb: 11, n: 8, gap: -1, abort: 0});
        wait_idle();
        start(8'h3C, 0, PAR_EVEN, 6'd16, '{bits: 11'b01001111000, nb: 10, n: 16, gap: -1, abort: 0});
        wait_idle();
        repeat (3) @(posedge clk);
        #1;
        chk("idle_after_3c", {bus.Busy, bus.TX_OUT}, 2'b01);
        start(8'hA5, 1, PAR_EVEN, 6'd8, '{bits: 11'b10101001010, nb: 11, n: 8, gap: -1, abort: 0});
        repeat (20) @(posedge clk);
        #1;
        bus.P_DATA = 8'hFF;
        bus.Data_Valid = 1'b1;
        @(posedge clk);
        #1;
        bus.Data_Valid = 1'b0;
        wait_idle();
        q.push_back('{bits: 11'b01100000010, nb: 10, n: 4, gap: -1, abort: 0});
        q.push_back('{bits: 11'b01100000010, nb: 10, n: 4, gap: 1, abort: 0});
        bus.P_DATA = 8'h81;
        bus.PAR_EN = 1'b0;
        bus.PAR_TYP = 1'b0;
        bus.Prescale = 6'd4;
        bus.Data_Valid = 1'b1;
        @(posedge clk);
        #1;
        chk("hold_first_start", {bus.Busy, bus.TX_OUT}, 2'b10);
        wait_idle();
        @(posedge clk);
        #1;
        chk("hold_second_start", {bus.Busy, bus.TX_OUT}, 2'b10);
        bus.Data_Valid = 1'b0;
        wait_idle();
        start(8'hA5, 1, PAR_EVEN, 6'd8, '{bits: 11'b10101001010, nb: 11, n: 8, gap: -1, abort: 1});
        repeat (35) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("abort_tx", bus.TX_OUT, 1);
        chk("abort_busy", bus.Busy, 0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;
        start(8'h55, 1, PAR_EVEN, 6'd8, '{bits: 11'b10010101010, nb: 11, n: 8, gap: -1, abort: 0});
        wait_idle();
        start(8'h01, 0, PAR_EVEN, 6'd2, '{bits: 11'b01000000010, nb: 10, n: 4, gap: -1, abort: 0});
        wait_idle();
        repeat (3) @(posedge clk);
        #1;
        chk("queue_empty", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
